// File: rtl/handshake_pkg.sv
// handshake_pkg: arbiter state encoding, default data width and ID-width helper shared by the arbiter files.
package handshake_pkg;
   typedef enum logic {ARB, LOCK} arb_state_e;
   localparam int DEF_WIDTH = 9;
   function automatic int id_width(input int n);
      return $clog2(n);
   endfunction
endpackage

// File: rtl/rr_handshake_arbiter_if.sv
// rr_handshake_arbiter_if: multi-source valid/ready channel into the arbiter and its single output channel.
// src_last is present only when ARB_BURST_EN is defined.
interface rr_handshake_arbiter_if import handshake_pkg::*; #(
   parameter int WIDTH = DEF_WIDTH,
   parameter int NUM_SRC = 4,
   parameter int ID_W = id_width(NUM_SRC)
);
   logic [NUM_SRC-1:0] src_vaild;
   logic [NUM_SRC-1:0] src_ready;
   logic [NUM_SRC*WIDTH-1:0] src_data_in;
`ifdef ARB_BURST_EN
   logic [NUM_SRC-1:0] src_last;
`endif
   logic dst_vaild;
   logic dst_ready;
   logic idle;
   logic [WIDTH-1:0] dst_data_out;
   logic [ID_W-1:0] dst_id;
   modport master (
      output src_vaild, src_data_in, dst_ready,
`ifdef ARB_BURST_EN
      output src_last,
`endif
      input src_ready, dst_vaild, dst_data_out, dst_id, idle
   );
   modport slave (
      input src_vaild, src_data_in, dst_ready,
`ifdef ARB_BURST_EN
      input src_last,
`endif
      output src_ready, dst_vaild, dst_data_out, dst_id, idle
   );
endinterface

// File: rtl/rr_handshake_arbiter_grant.sv
// rr_grant: combinational round-robin selector; first requester at or after ptr wins, wrapping at NUM_SRC.
module rr_grant #(
   parameter int NUM_SRC = 4,
   parameter int ID_W = 2
) (
   input  logic [NUM_SRC-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   output logic [NUM_SRC-1:0] grant,
   output logic [ID_W-1:0]    idx
);
   int k;
   // Scan farthest-first so the requester nearest to ptr is written last and wins.
   always_comb begin
      grant = '0;
      idx = '0;
      k = 0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         k = (int'(ptr) + i) % NUM_SRC;
         if (req[k]) begin
            grant = '0;
            grant[k] = 1'b1;
            idx = ID_W'(k);
         end
      end
   end
endmodule

// File: rtl/rr_handshake_arbiter.sv
// rr_handshake_arbiter: round-robin N:1 valid/ready arbiter with a registered, source-tagged output word.
// Define ARB_BURST_EN to hold the grant on one source until its src_last beat.
module rr_handshake_arbiter import handshake_pkg::*; #(
   parameter int WIDTH = DEF_WIDTH,
   parameter int NUM_SRC = 4,
   parameter int ID_W = id_width(NUM_SRC)
) (
   input logic clk,
   input logic s_rst,
   rr_handshake_arbiter_if.slave bus
);
   arb_state_e state_q, state_d;
   logic [ID_W-1:0] ptr_q, ptr_d, dst_id_q, dst_id_d, idx, nxt;
   logic [WIDTH-1:0] dst_data_q, dst_data_d;
   logic dst_vaild_q, dst_vaild_d, slot_free, accept, last;
   logic [NUM_SRC-1:0] req, grant;
   assign slot_free = ~dst_vaild_q | bus.dst_ready;
   // In LOCK the burst owner is always the most recently accepted source, i.e. dst_id_q.
   assign req = (state_q == LOCK) ? (bus.src_vaild & (NUM_SRC'(1) << dst_id_q)) : bus.src_vaild;
   rr_grant #(.NUM_SRC(NUM_SRC), .ID_W(ID_W)) u_grant (
      .req(req),
      .ptr(ptr_q),
      .grant(grant),
      .idx(idx)
   );
   assign bus.src_ready = grant & {NUM_SRC{slot_free}};
   assign accept = |bus.src_ready;
   assign nxt = (int'(idx) == NUM_SRC - 1) ? '0 : idx + 1'b1;
`ifdef ARB_BURST_EN
   assign last = bus.src_last[idx];
`else
   assign last = 1'b1;
`endif
   always_comb begin
      dst_vaild_d = accept | (dst_vaild_q & ~bus.dst_ready);
      dst_data_d = accept ? bus.src_data_in[int'(idx)*WIDTH +: WIDTH] : dst_data_q;
      dst_id_d = accept ? idx : dst_id_q;
      ptr_d = (accept & last) ? nxt : ptr_q;
      state_d = accept ? (last ? ARB : LOCK) : state_q;
   end
   always_ff @(posedge clk or posedge s_rst) begin
      if (s_rst) begin
         state_q <= ARB;
         ptr_q <= '0;
         dst_id_q <= '0;
         dst_data_q <= '0;
         dst_vaild_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q <= ptr_d;
         dst_id_q <= dst_id_d;
         dst_data_q <= dst_data_d;
         dst_vaild_q <= dst_vaild_d;
      end
   end
   assign bus.dst_vaild = dst_vaild_q;
   assign bus.dst_data_out = dst_data_q;
   assign bus.dst_id = dst_id_q;
   assign bus.idle = ~dst_vaild_q & ~|bus.src_vaild;
endmodule

// File: tb/tb_rr_handshake_arbiter.sv
// tb_rr_handshake_arbiter: vector table, hand-written reset/burst sequences and a randomized run against a reference model.
module tb_rr_handshake_arbiter;
   localparam int N = 4;
   localparam int W = 9;
   logic clk = 1'b0;
   logic s_rst = 1'b1;
   int n_cmp = 0;
   int n_err = 0;
   rr_handshake_arbiter_if #(.WIDTH(W), .NUM_SRC(N), .ID_W(2)) bus ();
   rr_handshake_arbiter #(.WIDTH(W), .NUM_SRC(N), .ID_W(2)) dut (
      .clk(clk),
      .s_rst(s_rst),
      .bus(bus)
   );
   always #5 clk = ~clk;

   typedef struct {
      logic [N-1:0] v;
      logic [W-1:0] base;
      logic         rdy;
      logic [N-1:0] e_rdy;
      logic         e_idle;
      logic         e_dv;
      logic [1:0]   e_id;
      logic [W-1:0] e_data;
   } vec_t;
   vec_t tbl [12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic [N-1:0] v, input logic [W-1:0] base, input logic r);
      bus.src_vaild = v;
      for (int k = 0; k < N; k++) bus.src_data_in[k*W +: W] = base + W'(k);
      bus.dst_ready = r;
   endtask

   task automatic do_reset();
      @(negedge clk);
      s_rst = 1'b1;
      drive('0, '0, 1'b0);
      @(negedge clk);
      s_rst = 1'b0;
   endtask

   // Reference model: abstract state is "priority start", "held word", "held tag", "word present".
   int m_ptr, m_id, win;
   logic m_dv;
   logic [W-1:0] m_data;
   logic [N-1:0] e_rdy;
   logic [63:0] r64;

   initial begin
      tbl[0]  = '{4'b0100, 9'h053, 1'b1, 4'b0100, 1'b0, 1'b1, 2'd2, 9'h055};
      tbl[1]  = '{4'b1001, 9'h100, 1'b1, 4'b1000, 1'b0, 1'b1, 2'd3, 9'h103};
      tbl[2]  = '{4'b1001, 9'h100, 1'b1, 4'b0001, 1'b0, 1'b1, 2'd0, 9'h100};
      tbl[3]  = '{4'b1111, 9'h1f0, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd0, 9'h100};
      tbl[4]  = '{4'b1111, 9'h1f0, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd0, 9'h100};
      tbl[5]  = '{4'b1111, 9'h1f0, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd0, 9'h100};
      tbl[6]  = '{4'b1111, 9'h1f0, 1'b1, 4'b0010, 1'b0, 1'b1, 2'd1, 9'h1f1};
      tbl[7]  = '{4'b1111, 9'h020, 1'b1, 4'b0100, 1'b0, 1'b1, 2'd2, 9'h022};
      tbl[8]  = '{4'b1111, 9'h020, 1'b1, 4'b1000, 1'b0, 1'b1, 2'd3, 9'h023};
      tbl[9]  = '{4'b1111, 9'h020, 1'b1, 4'b0001, 1'b0, 1'b1, 2'd0, 9'h020};
      tbl[10] = '{4'b0000, 9'h000, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 9'h020};
      tbl[11] = '{4'b0000, 9'h000, 1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 9'h020};
`ifdef ARB_BURST_EN
      bus.src_last = '1;
`endif
      drive('0, '0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("reset_dv", 32'(bus.dst_vaild), 32'd0);
      chk("reset_id", 32'(bus.dst_id), 32'd0);
      chk("reset_data", 32'(bus.dst_data_out), 32'd0);
      chk("reset_idle", 32'(bus.idle), 32'd1);
      chk("reset_ready", 32'(bus.src_ready), 32'd0);
      s_rst = 1'b0;

      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         drive(tbl[i].v, tbl[i].base, tbl[i].rdy);
         #1;
         chk($sformatf("tbl%0d_ready", i), 32'(bus.src_ready), 32'(tbl[i].e_rdy));
         chk($sformatf("tbl%0d_idle", i), 32'(bus.idle), 32'(tbl[i].e_idle));
         @(posedge clk);
         #1;
         chk($sformatf("tbl%0d_dv", i), 32'(bus.dst_vaild), 32'(tbl[i].e_dv));
         chk($sformatf("tbl%0d_id", i), 32'(bus.dst_id), 32'(tbl[i].e_id));
         chk($sformatf("tbl%0d_data", i), 32'(bus.dst_data_out), 32'(tbl[i].e_data));
      end

      // Asynchronous reset while a word is held, then a fresh grant.
      @(negedge clk);
      drive(4'b0100, 9'h0a0, 1'b0);
      @(posedge clk);
      #1;
      chk("ar_pre_dv", 32'(bus.dst_vaild), 32'd1);
      chk("ar_pre_id", 32'(bus.dst_id), 32'd2);
      #2;
      s_rst = 1'b1;
      #1;
      chk("ar_dv", 32'(bus.dst_vaild), 32'd0);
      chk("ar_id", 32'(bus.dst_id), 32'd0);
      @(negedge clk);
      s_rst = 1'b0;
      drive(4'b0010, 9'h0b0, 1'b1);
      #1;
      chk("ar_post_ready", 32'(bus.src_ready), 32'b0010);
      @(posedge clk);
      #1;
      chk("ar_post_dv", 32'(bus.dst_vaild), 32'd1);
      chk("ar_post_id", 32'(bus.dst_id), 32'd1);
      chk("ar_post_data", 32'(bus.dst_data_out), 32'h0b1);

`ifdef ARB_BURST_EN
      do_reset();
      drive(4'b0001, 9'h010, 1'b1);
      @(posedge clk);
      #1;
      chk("burst_pre_id", 32'(bus.dst_id), 32'd0);
      for (int b = 0; b < 4; b++) begin
         @(negedge clk);
         drive(4'b0011, 9'h040 + W'(b * 8), 1'b1);
         bus.src_last = (b == 2) ? 4'b0010 : 4'b0000;
         @(posedge clk);
         #1;
         chk($sformatf("burst%0d_id", b), 32'(bus.dst_id), (b < 3) ? 32'd1 : 32'd0);
      end
      @(negedge clk);
      bus.src_last = '1;
`endif

      do_reset();
      m_ptr = 0;
      m_id = 0;
      m_dv = 1'b0;
      m_data = '0;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         r64 = {$urandom, $urandom};
         bus.src_vaild = N'($urandom_range(0, 15));
         bus.src_data_in = r64[N*W-1:0];
         bus.dst_ready = ($urandom_range(0, 3) != 0);
         win = -1;
         if (!m_dv || bus.dst_ready)
            for (int off = 0; off < N; off++)
               if (win < 0 && bus.src_vaild[(m_ptr + off) % N]) win = (m_ptr + off) % N;
         e_rdy = (win >= 0) ? N'(1 << win) : '0;
         #1;
         chk("rnd_ready", 32'(bus.src_ready), 32'(e_rdy));
         chk("rnd_idle", 32'(bus.idle), 32'(!m_dv && bus.src_vaild == 0));
         if (win >= 0) begin
            m_data = bus.src_data_in[win*W +: W];
            m_id = win;
            m_dv = 1'b1;
            m_ptr = (win + 1) % N;
         end else if (bus.dst_ready) m_dv = 1'b0;
         @(posedge clk);
         #1;
         chk("rnd_dv", 32'(bus.dst_vaild), 32'(m_dv));
         chk("rnd_id", 32'(bus.dst_id), 32'(m_id));
         chk("rnd_data", 32'(bus.dst_data_out), 32'(m_data));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
